burst_scheduler: RTL and testbench
==================================

BURST_SCHEDULER -- requirements
Module: burst_scheduler

Interface
REQ-001 Parameters: none; counter width is fixed at 3 bits and burst length encoding is len+1 (range 1..8 ticks).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on posedge clk.
REQ-004 req  input  2  per-requester burst request, level-sensitive; bit i belongs to requester i.
REQ-005 len0  input  3  burst length minus one for requester 0, sampled only at grant.
REQ-006 len1  input  3  burst length minus one for requester 1, sampled only at grant.
REQ-007 grant  output  2  one-hot owner of the shared counter, registered.
REQ-008 tick  output  1  counter-enable strobe, high for each active burst cycle.
REQ-009 count  output  3  current shared-counter value.
REQ-010 done  output  2  one-cycle completion pulse for the served requester.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and DONE; unused encodings SHALL go to IDLE.
REQ-013 In IDLE with req != 0, the FSM SHALL select a winner, latch the winner's len into burst_len, set grant, and enter RUN on the next edge.
REQ-014 Arbitration SHALL be round-robin: with both requests high, the requester not served last wins; with one request high, that requester wins.
REQ-015 In IDLE with req == 0, the FSM SHALL remain in IDLE, with grant=00, tick=0 and count held at 0.
REQ-016 In RUN, tick SHALL be 1; count SHALL start at 0 on the first RUN cycle and increment by 1 per cycle while count != burst_len.
REQ-017 RUN SHALL last exactly burst_len+1 cycles; on the edge where count == burst_len, the FSM SHALL enter DONE, and count SHALL hold at burst_len without wrapping, including for burst_len=7.
REQ-018 In DONE (one cycle):
  - done[winner] SHALL be 1 and grant SHALL be 00;
  - the last-served pointer SHALL update to the winner;
  - the next state SHALL be IDLE, where count clears to 0.
REQ-019 Latency: req sampled high in IDLE at edge k gives grant/tick at cycle k+1, done at cycle k+burst_len+2, and the earliest next grant at cycle k+burst_len+4.
REQ-020 Deasserting req or changing len during RUN SHALL NOT affect the active burst.
REQ-021 A requester still holding req after its done pulse SHALL be rearbitrated; under contention, the other requester wins.
REQ-022 grant SHALL never have both bits set, and done SHALL never have both bits set.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL enter IDLE with grant=00, tick=0, count=0, done=00, busy=0, and last-served pointer set to 1 so that requester 0 wins first.
REQ-024 Reset mid-burst SHALL abort the burst with no done pulse; rst SHALL take priority over all other inputs.

Structure
REQ-025 The state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the counter width constant SHALL live in a shared package/header.
REQ-026 The shared counter SHALL be a sub-module tick_counter (3-bit, synchronous clear, enable, hold); burst_scheduler contains the FSM, arbiter and burst_len register.

Verification
REQ-027 Reset check: rst held 2 cycles then released, req=00 -> grant=00, count=0, busy=0 indefinitely.
REQ-028 Single burst: req=01, len0=3 -> grant=01 for 4 cycles with count 0,1,2,3; done=01 for one cycle; then count=0.
REQ-029 Contention: req=11 held, len0=1, len1=2 -> served in order requester 0 (2 ticks), then 1 (3 ticks), then 0; no overlap between grants.
REQ-030 Boundary: len1=7 -> 8 tick cycles, count reaches 7 and holds through DONE without wrapping to 0.
REQ-031 Mid-burst changes: req dropped and len changed during RUN -> burst still completes at the originally latched length with done pulse.
REQ-032 Reset mid-burst: rst asserted at count=2 -> next cycle IDLE, count=0, no done pulse; after release, req=11 -> requester 0 granted first.

Source files
------------

// File: rtl/burst_scheduler_pkg.sv
// burst_scheduler_pkg: shared FSM encodings and counter width for the burst scheduler
package burst_scheduler_pkg;
    localparam int CNT_W = 3;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
endpackage

// File: rtl/burst_scheduler_if.sv
// burst_scheduler_if: requester-side request/length inputs and scheduler status outputs
interface burst_scheduler_if;
    import burst_scheduler_pkg::*;
    logic [1:0]       req;
    logic [CNT_W-1:0] len0;
    logic [CNT_W-1:0] len1;
    logic [1:0]       grant;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic [1:0]       done;
    logic             busy;
    modport master (output req, len0, len1, input grant, tick, count, done, busy);
    modport slave  (input req, len0, len1, output grant, tick, count, done, busy);
endinterface

// File: rtl/burst_scheduler_tick_counter.sv
// tick_counter: shared counter with synchronous clear, enable and hold
module tick_counter
    import burst_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_q, count_d;
    always_comb count_d = clr ? '0 : en ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign count = count_q;
endmodule

// File: rtl/burst_scheduler.sv
// burst_scheduler: round-robin owner of a shared tick counter, running one len+1 tick burst per grant
module burst_scheduler
    import burst_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    burst_scheduler_if.slave bus
);
    state_t           state_q, state_d;
    logic [1:0]       grant_q, grant_d;
    logic             win_q, win_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt;
    logic             sel;
    // with both requesting, the one not served last wins; otherwise the lone requester
    assign sel = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        win_d   = win_q;
        last_d  = last_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                grant_d = 2'b00;
                if (bus.req != 2'b00) begin
                    win_d   = sel;
                    len_d   = sel ? bus.len1 : bus.len0;
                    grant_d = sel ? 2'b10 : 2'b01;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt == len_q) begin
                    grant_d = 2'b00;
                    state_d = DONE;
                end
            end
            DONE: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            win_q   <= 1'b0;
            last_q  <= 1'b1;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            win_q   <= win_d;
            last_q  <= last_d;
            len_q   <= len_d;
        end
    end
    // count holds at burst_len through DONE and clears on the way back to IDLE
    tick_counter u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_q != RUN),
        .en    (state_q == RUN && cnt != len_q),
        .count (cnt)
    );
    assign bus.count = cnt;
    assign bus.grant = grant_q;
    assign bus.tick  = state_q == RUN;
    assign bus.done  = (state_q == DONE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.busy  = state_q != IDLE;
endmodule

// File: tb/tb_burst_scheduler.sv
// tb_burst_scheduler: directed checks of arbitration, burst timing, boundaries and reset
module tb_burst_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    burst_scheduler_if bus();
    burst_scheduler dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, {6'd0, bus.grant}, 8'h00);
        chk({tag, "_count"}, {5'd0, bus.count}, 8'h00);
        chk({tag, "_busy"}, {7'd0, bus.busy}, 8'h00);
        chk({tag, "_tick"}, {7'd0, bus.tick}, 8'h00);
        chk({tag, "_done"}, {6'd0, bus.done}, 8'h00);
    endtask

    // expects the next edge to grant g for a burst of l+1 ticks; mid drops req and scrambles lengths after the first tick
    task automatic burst(input logic [1:0] g, input int l, input bit mid);
        for (int i = 0; i <= l; i++) begin
            step();
            chk("run_grant", {6'd0, bus.grant}, {6'd0, g});
            chk("run_tick", {7'd0, bus.tick}, 8'h01);
            chk("run_count", {5'd0, bus.count}, 8'(i));
            chk("run_busy", {7'd0, bus.busy}, 8'h01);
            chk("run_done", {6'd0, bus.done}, 8'h00);
            if (mid && i == 0) begin
                bus.req  = 2'b00;
                bus.len0 = 3'd7;
                bus.len1 = 3'd0;
            end
        end
        step();
        chk("done_pulse", {6'd0, bus.done}, {6'd0, g});
        chk("done_grant", {6'd0, bus.grant}, 8'h00);
        chk("done_count", {5'd0, bus.count}, 8'(l));
        chk("done_tick", {7'd0, bus.tick}, 8'h00);
        chk("done_busy", {7'd0, bus.busy}, 8'h01);
        step();
        chk_idle("post");
    endtask

    initial begin
        bus.req  = 2'b00;
        bus.len0 = 3'd0;
        bus.len1 = 3'd0;
        step();
        step();
        chk_idle("reset");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("idle");
        end
        bus.req  = 2'b01;
        bus.len0 = 3'd3;
        burst(2'b01, 3, 1'b1);
        bus.req  = 2'b10;
        bus.len1 = 3'd7;
        burst(2'b10, 7, 1'b1);
        bus.req  = 2'b11;
        bus.len0 = 3'd1;
        bus.len1 = 3'd2;
        burst(2'b01, 1, 1'b0);
        burst(2'b10, 2, 1'b0);
        burst(2'b01, 1, 1'b0);
        bus.req = 2'b00;
        step();
        chk_idle("drain");
        bus.req  = 2'b01;
        bus.len0 = 3'd2;
        burst(2'b01, 2, 1'b1);
        bus.req  = 2'b10;
        bus.len1 = 3'd5;
        step();
        step();
        step();
        chk("pre_rst_count", {5'd0, bus.count}, 8'h02);
        chk("pre_rst_grant", {6'd0, bus.grant}, 8'h02);
        rst = 1'b1;
        step();
        chk_idle("abort");
        rst = 1'b0;
        bus.req  = 2'b11;
        bus.len0 = 3'd0;
        bus.len1 = 3'd0;
        burst(2'b01, 0, 1'b0);
        burst(2'b10, 0, 1'b0);
        bus.req = 2'b00;
        step();
        chk_idle("final");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
